// File: rtl/c_pipe_hs_sink.sv
// Clocked sink for a Muller-C micropipeline: 4-phase RZ req/ack handshake in,
// capture FIFO, and a valid/ready word stream out to the synchronous side.
//
// state   | meaning
// WAIT_LO | after reset; wait for a settled, low request before accepting words
// IDLE    | ack low; capture on synchronized request if the FIFO has room
// ACK     | ack high; wait for request to return to zero, watch for a stall
module c_pipe_hs_sink #(
  parameter int DATA_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          hs_req_i,
  input  logic [DATA_W-1:0]             hs_data_i,
  output logic                          hs_ack_o,
  output logic                          out_valid_o,
  output logic [DATA_W-1:0]             out_data_o,
  input  logic                          out_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [15:0]                   hs_count_o,
  output logic                          err_timeout_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int SET_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    WAIT_LO = 2'd0,
    IDLE    = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_n;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     req_s;
  logic [SET_W-1:0]         settle;
  logic                     ack_q;
  logic                     ack_n;
  logic [TO_W-1:0]          to_cnt;
  logic                     to_clr;
  logic                     to_inc;
  logic                     err_q;
  logic [15:0]              count_q;

  logic [DATA_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [LVL_W-1:0]         level;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;

  // Request synchronizer; req_s is the only view of hs_req_i.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], hs_req_i};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // The cleared synchronizer reads low right after reset even if the sender
  // still holds req high; wait until it has refilled with real samples.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)            settle <= SET_W'(SYNC_STAGES);
    else if (settle != '0)   settle <= settle - 1'b1;
  end

  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign pop   = ~empty & out_ready_i;

  always_comb begin
    state_n = state;
    ack_n   = 1'b0;
    push    = 1'b0;
    to_clr  = 1'b0;
    to_inc  = 1'b0;
    case (state)
      WAIT_LO: begin
        if (settle == '0 && !req_s) state_n = IDLE;
      end
      IDLE: begin
        if (req_s && !full) begin
          push    = 1'b1;
          ack_n   = 1'b1;
          state_n = ACK;
        end
      end
      ACK: begin
        ack_n = 1'b1;
        if (!req_s) begin
          ack_n   = 1'b0;
          to_clr  = 1'b1;
          state_n = IDLE;
        end else begin
          to_inc = 1'b1;
        end
      end
      default: state_n = WAIT_LO;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= WAIT_LO;
      ack_q <= 1'b0;
    end else begin
      state <= state_n;
      ack_q <= ack_n;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (to_clr)
        to_cnt <= '0;
      else if (to_inc && to_cnt != TO_W'(TIMEOUT))
        to_cnt <= to_cnt + 1'b1;
      if (to_inc && to_cnt == TO_W'(TIMEOUT - 1))
        err_q <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)  count_q <= '0;
    else if (push) count_q <= count_q + 16'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= hs_data_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign hs_ack_o      = ack_q;
  assign out_valid_o   = ~empty;
  assign out_data_o    = empty ? '0 : mem[rd_ptr];
  assign fifo_level_o  = level;
  assign hs_count_o    = count_q;
  assign err_timeout_o = err_q;

endmodule
